// File: rtl/clock_monitor_pkg.sv
// Shared types for the oscillator clock monitor and for blocks that consume
// its status.
//   state_t : monitor FSM state (IDLE, ACQUIRE, LOCKED, FAULT)
//   fault_t : 2-bit fault classification reported on fault_code
//   DEF_*   : default monitor parameters for the standard oscillator
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10,
    FAULT   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_NONE  = 2'b00,
    F_STUCK = 2'b01,
    F_SLOW  = 2'b10,
    F_FAST  = 2'b11
  } fault_t;

  localparam int DEF_EXP_PERIOD = 100;
  localparam int DEF_TOL        = 4;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with rising-edge detect.
// Ports:
//   clock    in  destination clock
//   reset_n  in  synchronous active-low reset, clears all flops
//   async_in in  signal from an unrelated clock domain
//   sync     out synchronized level (second flop)
//   rise     out one-cycle pulse while sync is 1 and was 0 the cycle before
module edge_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic sync,
  output logic rise
);

  logic meta;
  logic sync_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/clock_monitor.sv
// Oscillator clock monitor. Samples mon_clk in the system clock domain,
// measures its period and high time in system cycles, and reports whether
// the oscillator is locked, stuck, too slow or too fast.
// Ports:
//   clock        in  system clock, all logic on the rising edge
//   reset_n      in  synchronous active-low reset
//   enable       in  monitor enable (follows oscillator power); 0 forces IDLE
//   mon_clk      in  monitored clock, asynchronous to clock
//   clear_fault  in  one-cycle pulse: leave FAULT and restart acquisition
//   period       out last measured mon_clk period in system cycles
//   high_time    out system cycles mon_clk was sampled high in that period
//   period_valid out one-cycle pulse when period/high_time update
//   locked       out high only in LOCKED
//   fault        out high only in FAULT
//   fault_code   out fault_t classification (sticky while in FAULT)
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = 2 * EXP_PERIOD,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mon_clk,
  input  logic             clear_fault,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  // Tolerance window in CNT_W+1 bits so EXP_PERIOD+TOL never wraps and the
  // lower bound is clamped at zero instead of underflowing.
  localparam int               LO_I      = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam logic [CNT_W:0]   TOL_LO    = (CNT_W + 1)'(LO_I);
  localparam logic [CNT_W:0]   TOL_HI    = (CNT_W + 1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic              sync;
  logic              rise;
  state_t            state;
  state_t            state_next;
  fault_t            fault_q;
  fault_t            fault_next;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hcnt;
  logic              discard;
  logic              clear_go;
  logic              timeout;
  logic [CNT_W:0]    period_ext;
  logic              period_ok;
  logic              period_slow;

  edge_sync u_edge_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (mon_clk),
    .sync     (sync),
    .rise     (rise)
  );

  // Tolerance is judged on the registered period while period_valid is
  // high, so a lock or frequency fault lands the cycle after the pulse.
  assign period_ext  = {1'b0, period};
  assign period_ok   = (period_ext >= TOL_LO) && (period_ext <= TOL_HI);
  assign period_slow = (period_ext > TOL_HI);
  assign timeout     = (cnt >= TIMEOUT_C);

  always_comb begin
    state_next = state;
    fault_next = fault_q;
    good_next  = good_cnt;
    clear_go   = 1'b0;
    case (state)
      IDLE: begin
        state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (timeout) begin
          state_next = FAULT;
          fault_next = F_STUCK;
        end else if (period_valid) begin
          if (!period_ok) begin
            good_next = '0;
          end else if (good_cnt == GOOD_LAST) begin
            state_next = LOCKED;
            good_next  = '0;
          end else begin
            good_next = good_cnt + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_next = FAULT;
          fault_next = F_STUCK;
        end else if (period_valid && !period_ok) begin
          state_next = FAULT;
          fault_next = period_slow ? F_SLOW : F_FAST;
        end
      end
      FAULT: begin
        // Clear beats any fault condition seen in the same cycle; the
        // restarted acquisition re-evaluates from scratch.
        if (clear_fault) begin
          state_next = ACQUIRE;
          fault_next = F_NONE;
          good_next  = '0;
          clear_go   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!enable) begin
      state_next = IDLE;
      fault_next = F_NONE;
      good_next  = '0;
      clear_go   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      fault_q      <= F_NONE;
      good_cnt     <= '0;
      cnt          <= '0;
      hcnt         <= '0;
      discard      <= 1'b1;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_next;
      fault_q      <= fault_next;
      good_cnt     <= good_next;
      period_valid <= 1'b0;
      if (!enable || state == IDLE) begin
        cnt       <= '0;
        hcnt      <= '0;
        discard   <= 1'b1;
        period    <= '0;
        high_time <= '0;
      end else if (clear_go) begin
        cnt     <= '0;
        hcnt    <= '0;
        discard <= 1'b1;
      end else if (rise) begin
        // The first rise after (re)starting acquisition only aligns the
        // counters; the partial period before it is meaningless.
        cnt     <= CNT_W'(1);
        hcnt    <= CNT_W'(1);
        discard <= 1'b0;
        if (!discard) begin
          period       <= cnt;
          high_time    <= hcnt;
          period_valid <= 1'b1;
        end
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        if (sync && (hcnt != CNT_MAX)) begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  assign locked     = (state == LOCKED);
  assign fault      = (state == FAULT);
  assign fault_code = fault_q;

endmodule

// File: tb/tb_clock_monitor.sv
module tb_clock_monitor;

  localparam int EXP_P  = 100;
  localparam int TOL    = 4;
  localparam int LOCK_N = 4;
  localparam int TOUT   = 200;
  localparam int CNT_W  = 16;
  localparam int HMAX   = 30000;

  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_LOCK  = 2;
  localparam int M_FAULT = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             mon_clk;
  logic             clear_fault;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;

  clock_monitor dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .mon_clk      (mon_clk),
    .clear_fault  (clear_fault),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // scoreboard state
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [CNT_W-1:0] exp_q[$];

  // reference model: mon_clk as sampled at each system edge, plus
  // event-level bookkeeping derived from rise-to-rise distances
  bit hist [HMAX];
  int n      = 0;
  int md     = M_IDLE;
  int good   = 0;
  int code   = 0;
  int z      = 0;   // edge after which the elapsed-cycle count was zero
  int p      = 0;   // edge at which the last counted rise acted
  int disc   = 1;
  int e_pv   = 0;
  int e_per  = 0;
  int e_high = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    bit rise_now;
    bit tout;
    bit ok;
    bit go;
    int pv_prev;
    int per_prev;
    int sum;
    if (n >= HMAX) begin
      $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", n, HMAX);
      $fatal(1);
    end
    pv_prev  = e_pv;
    per_prev = e_per;
    go       = 1'b0;
    hist[n]  = mon_clk;
    // A level change seen by the edge n-2 sample is acted on at edge n.
    rise_now = (n >= 3) && hist[n-2] && !hist[n-3];
    if (!reset_n) begin
      md = M_IDLE; good = 0; code = 0; e_pv = 0; e_per = 0; e_high = 0; z = n; disc = 1;
      for (int k = n - 2; k <= n; k++) if (k >= 0) hist[k] = 1'b0;
    end else if (!enable || md == M_IDLE) begin
      md = enable ? M_ACQ : M_IDLE;
      good = 0; code = 0; e_pv = 0; e_per = 0; e_high = 0; z = n; disc = 1;
    end else begin
      ok   = (per_prev >= EXP_P - TOL) && (per_prev <= EXP_P + TOL);
      tout = (n - 1 - z) >= TOUT;
      case (md)
        M_ACQ: begin
          if (tout) begin
            md = M_FAULT; code = 1;
          end else if (pv_prev != 0) begin
            if (ok) begin
              good++;
              if (good == LOCK_N) begin md = M_LOCK; good = 0; end
            end else good = 0;
          end
        end
        M_LOCK: begin
          if (tout) begin
            md = M_FAULT; code = 1;
          end else if (pv_prev != 0 && !ok) begin
            md = M_FAULT; code = (per_prev > EXP_P + TOL) ? 2 : 3;
          end
        end
        M_FAULT: begin
          if (clear_fault) begin md = M_ACQ; code = 0; good = 0; go = 1'b1; end
        end
        default: ;
      endcase
      e_pv = 0;
      if (go) begin
        z = n; disc = 1;
      end else if (rise_now) begin
        if (disc == 0) begin
          sum = 0;
          for (int k = p - 2; k <= n - 3; k++) sum += int'(hist[k]);
          e_per  = sat(n - p);
          e_high = sat(sum);
          e_pv   = 1;
          exp_q.push_back(CNT_W'(e_per));
        end
        disc = 0; p = n; z = n - 1;
      end
    end
    n++;
  endtask

  // one system cycle: model on the rising edge, compare on the falling edge
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("locked", locked, md == M_LOCK);
    check("fault", fault, md == M_FAULT);
    check("fault_code", fault_code, code);
    check("period_valid", period_valid, e_pv);
    check("period", period, e_per);
    check("high_time", high_time, e_high);
    if (period_valid === 1'b1) begin
      check("sb_pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_period", period, exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic run(input int hi, input int lo);
    mon_clk = 1'b1;
    repeat (hi) cycle();
    mon_clk = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic run_nominal(input int count);
    repeat (count) run(50, 50);
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    cycle();
    clear_fault = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_code"}, fault_code, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_pv"}, period_valid, 0);
  endtask

  initial begin
    int per;
    int hi;
    reset_n = 1'b0; enable = 1'b0; mon_clk = 1'b0; clear_fault = 1'b0;
    repeat (3) begin
      mon_clk = 1'($urandom_range(0, 1));
      cycle();
    end
    check_idle_outputs("reset");

    // idle with a wiggling mon_clk: nothing may be reported
    reset_n = 1'b1;
    repeat (8) begin
      mon_clk = 1'($urandom_range(0, 1));
      cycle();
    end
    mon_clk = 1'b0;
    repeat (4) cycle();
    check_idle_outputs("idle");

    // nominal acquisition: discard + 4 periods
    enable = 1'b1;
    run_nominal(6);
    check("nom_locked", locked, 1);
    check("nom_fault", fault, 0);
    check("nom_period", period, 100);
    check("nom_high", high_time, 50);

    // random in-tolerance periods and duty cycles keep lock
    repeat (6) begin
      per = $urandom_range(EXP_P - TOL, EXP_P + TOL);
      hi  = $urandom_range(2, per - 2);
      run(hi, per - hi);
    end
    check("jitter_locked", locked, 1);

    // tolerance edges are inclusive, then slow fault
    run(52, 52);
    run(48, 48);
    run(50, 50);
    check("edge_locked", locked, 1);
    run(55, 55);
    run(50, 50);
    check("slow_fault", fault, 1);
    check("slow_code", fault_code, 2);
    check("slow_locked", locked, 0);

    // clear, relock, then fast fault
    pulse_clear();
    check("clear_fault", fault, 0);
    check("clear_code", fault_code, 0);
    run_nominal(6);
    check("relock", locked, 1);
    run(45, 45);
    run(50, 50);
    check("fast_code", fault_code, 3);

    // an out-of-tolerance period restarts the lock count
    pulse_clear();
    run_nominal(3);
    run(60, 60);
    run_nominal(4);
    check("acq_not_yet", locked, 0);
    run_nominal(1);
    check("acq_locked", locked, 1);

    // stuck low
    mon_clk = 1'b0;
    repeat (205) cycle();
    check("stuck_fault", fault, 1);
    check("stuck_code", fault_code, 1);
    check("stuck_locked", locked, 0);
    // clear while the timeout condition still holds
    pulse_clear();
    check("clr_tout_fault", fault, 0);
    check("clr_tout_code", fault_code, 0);
    repeat (210) cycle();
    check("restuck_code", fault_code, 1);
    pulse_clear();
    run_nominal(6);
    check("stuck_relock", locked, 1);

    // enable drop mid-LOCKED
    mon_clk = 1'b1;
    repeat (20) cycle();
    enable = 1'b0;
    cycle();
    check_idle_outputs("disable");
    enable = 1'b1;
    repeat (30) cycle();
    mon_clk = 1'b0;
    repeat (50) cycle();
    run_nominal(6);
    check("enable_relock", locked, 1);

    // reset pulse mid-LOCKED
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_idle_outputs("midreset");
    run_nominal(4);
    check("rst_not_yet", locked, 0);
    run_nominal(1);
    check("rst_relock", locked, 1);

    // random soak: mixed periods, duties, stray clears and enable drops
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) pulse_clear();
      if ($urandom_range(0, 11) == 0) begin
        enable = 1'b0;
        cycle();
        enable = 1'b1;
      end
      per = $urandom_range(86, 114);
      hi  = $urandom_range(2, per - 2);
      run(hi, per - hi);
    end

    enable = 1'b0;
    repeat (3) cycle();
    check_idle_outputs("final");
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
